// File: rtl/port_event_sequencer.sv
// Root-port connect/reset/suspend/resume sequencer driven by one shared 24-bit timer.
// Optional remote wake (resumeIntIn wakes SUSPENDED) enabled by PORT_SEQ_REMOTE_WAKE_EN.
module port_event_sequencer #(
  parameter int DEBOUNCE_CYCLES = 100000,
  parameter int RESET_CYCLES    = 600000,
  parameter int RECOVERY_CYCLES = 60000,
  parameter int RESUME_CYCLES   = 1200000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] connectStateIn,
  input  logic       connectionEventIn,
  input  logic       resumeIntIn,
  input  logic       resetReqIn,
  input  logic       suspendReqIn,
  input  logic       resumeReqIn,
  input  logic       irqAckIn,
  output logic       forceSE0Out,
  output logic       forceKOut,
  output logic       sofEnableOut,
  output logic       lowSpeedOut,
  output logic [2:0] portStateOut,
  output logic       irqOut,
  output logic [1:0] irqCauseOut
);

  // state        | meaning
  // DISCONNECTED | no device on the line
  // DEBOUNCE     | device seen, waiting for a stable line
  // ATTACHED     | device present, waiting for a port reset
  // BUS_RESET    | driving SE0
  // RECOVERY     | idle line after reset
  // ENABLED      | SOFs running
  // SUSPENDED    | SOFs stopped
  // RESUME_K     | driving K to wake the device
  typedef enum logic [2:0] {
    DISCONNECTED = 3'd0,
    DEBOUNCE     = 3'd1,
    ATTACHED     = 3'd2,
    BUS_RESET    = 3'd3,
    RECOVERY     = 3'd4,
    ENABLED      = 3'd5,
    SUSPENDED    = 3'd6,
    RESUME_K     = 3'd7
  } state_t;

  localparam logic [23:0] DEB_TC = 24'(DEBOUNCE_CYCLES - 1);
  localparam logic [23:0] RST_TC = 24'(RESET_CYCLES - 1);
  localparam logic [23:0] REC_TC = 24'(RECOVERY_CYCLES - 1);
  localparam logic [23:0] RES_TC = 24'(RESUME_CYCLES - 1);

  state_t      state, nxt;
  logic [23:0] timer;
  logic        restart, set_conn, set_resume, latch_speed;
  logic        line_valid, disconnect, resume_go;

  assign line_valid = (connectStateIn == 2'b01) || (connectStateIn == 2'b10);
  assign disconnect = connectionEventIn && (connectStateIn == 2'b00);

`ifdef PORT_SEQ_REMOTE_WAKE_EN
  assign resume_go = resumeReqIn | resumeIntIn;
`else
  logic unused_resume_int;
  assign unused_resume_int = resumeIntIn;
  assign resume_go = resumeReqIn;
`endif

  always_comb begin
    nxt         = state;
    restart     = 1'b0;
    set_conn    = 1'b0;
    set_resume  = 1'b0;
    latch_speed = 1'b0;
    case (state)
      DISCONNECTED: if (line_valid) nxt = DEBOUNCE;
      DEBOUNCE: begin
        if (!line_valid) nxt = DISCONNECTED;
        else if (connectionEventIn) restart = 1'b1;
        else if (timer == DEB_TC) begin
          nxt         = ATTACHED;
          latch_speed = 1'b1;
          set_conn    = 1'b1;
        end
      end
      ATTACHED:  if (resetReqIn) nxt = BUS_RESET;
      BUS_RESET: if (timer == RST_TC) nxt = RECOVERY;
      RECOVERY:  if (timer == REC_TC) nxt = ENABLED;
      ENABLED: begin
        if (resetReqIn) nxt = BUS_RESET;
        else if (suspendReqIn) nxt = SUSPENDED;
      end
      SUSPENDED: begin
        if (resetReqIn) nxt = BUS_RESET;
        else if (resume_go) nxt = RESUME_K;
      end
      RESUME_K: if (timer == RES_TC) begin
        nxt        = ENABLED;
        set_resume = 1'b1;
      end
      default: nxt = DISCONNECTED;
    endcase
    // Disconnect overrides any request, except while the host owns the line.
    if (disconnect && (state == ATTACHED || state == RECOVERY ||
                       state == ENABLED  || state == SUSPENDED)) begin
      nxt      = DISCONNECTED;
      set_conn = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= DISCONNECTED;
      timer        <= '0;
      forceSE0Out  <= 1'b0;
      forceKOut    <= 1'b0;
      sofEnableOut <= 1'b0;
      lowSpeedOut  <= 1'b0;
      irqCauseOut  <= 2'b00;
    end else begin
      state        <= nxt;
      timer        <= (nxt != state || restart) ? 24'd0 : timer + 24'd1;
      forceSE0Out  <= (nxt == BUS_RESET);
      forceKOut    <= (nxt == RESUME_K);
      sofEnableOut <= (nxt == ENABLED);
      if (latch_speed) lowSpeedOut <= (connectStateIn == 2'b01);
      irqCauseOut  <= (irqCauseOut & {2{~irqAckIn}}) | {set_resume, set_conn};
    end
  end

  assign portStateOut = state;
  assign irqOut       = |irqCauseOut;

endmodule

// File: tb/tb_port_event_sequencer.sv
// Directed bench for port_event_sequencer with timer parameters 8/16/4/12.
// Remote-wake expectation follows PORT_SEQ_REMOTE_WAKE_EN.
module tb_port_event_sequencer;

  logic       clk = 1'b0;
  logic       rst;
  logic [1:0] connectStateIn;
  logic       connectionEventIn, resumeIntIn, resetReqIn, suspendReqIn, resumeReqIn, irqAckIn;
  logic       forceSE0Out, forceKOut, sofEnableOut, lowSpeedOut, irqOut;
  logic [2:0] portStateOut;
  logic [1:0] irqCauseOut;

  int n_checks = 0;
  int n_fails  = 0;
  int cnt;

  port_event_sequencer #(
    .DEBOUNCE_CYCLES(8), .RESET_CYCLES(16), .RECOVERY_CYCLES(4), .RESUME_CYCLES(12)
  ) dut (
    .clk(clk), .rst(rst),
    .connectStateIn(connectStateIn), .connectionEventIn(connectionEventIn),
    .resumeIntIn(resumeIntIn), .resetReqIn(resetReqIn),
    .suspendReqIn(suspendReqIn), .resumeReqIn(resumeReqIn), .irqAckIn(irqAckIn),
    .forceSE0Out(forceSE0Out), .forceKOut(forceKOut), .sofEnableOut(sofEnableOut),
    .lowSpeedOut(lowSpeedOut), .portStateOut(portStateOut),
    .irqOut(irqOut), .irqCauseOut(irqCauseOut)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_checks++;
    assert (obs === exp)
      else begin
        n_fails++;
        $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
  endtask

  task automatic wait_state(input logic [2:0] s, input string tag);
    int k = 0;
    while (portStateOut !== s && k < 200) begin
      step();
      k++;
    end
    check(tag, 8'(portStateOut), 8'(s));
  endtask

  task automatic ack();
    irqAckIn = 1'b1; step(); irqAckIn = 1'b0;
  endtask

  initial begin
    rst = 1'b1; connectStateIn = 2'b00; connectionEventIn = 1'b0; resumeIntIn = 1'b0;
    resetReqIn = 1'b0; suspendReqIn = 1'b0; resumeReqIn = 1'b0; irqAckIn = 1'b0;
    repeat (3) step();
    rst = 1'b0;
    check("reset_state", 8'(portStateOut), 8'd0);
    check("reset_drives", 8'({forceSE0Out, forceKOut, sofEnableOut, lowSpeedOut}), 8'h0);
    check("reset_irq", 8'({irqOut, irqCauseOut}), 8'h0);

    // Full-speed connect, 8 debounce cycles
    connectStateIn = 2'b10; connectionEventIn = 1'b1; step(); connectionEventIn = 1'b0;
    check("deb_enter", 8'(portStateOut), 8'd1);
    repeat (7) step();
    check("deb_cycle8", 8'(portStateOut), 8'd1);
    step();
    check("attached_fs", 8'(portStateOut), 8'd2);
    check("fs_lowspeed", 8'(lowSpeedOut), 8'd0);
    check("fs_irq", 8'({irqOut, irqCauseOut}), 8'h5);
    ack();
    check("ack_clear", 8'({irqOut, irqCauseOut}), 8'h0);

    // Disconnect from ATTACHED
    connectStateIn = 2'b00; connectionEventIn = 1'b1; step(); connectionEventIn = 1'b0;
    check("attached_disc", 8'(portStateOut), 8'd0);
    check("attached_disc_irq", 8'(irqCauseOut), 8'h1);
    ack();

    // Low-speed connect with a line event at debounce cycle 5
    connectStateIn = 2'b01; connectionEventIn = 1'b1; step(); connectionEventIn = 1'b0;
    repeat (4) step();
    connectionEventIn = 1'b1; step(); connectionEventIn = 1'b0;
    repeat (7) step();
    check("deb_restart_hold", 8'(portStateOut), 8'd1);
    step();
    check("attached_ls", 8'(portStateOut), 8'd2);
    check("ls_lowspeed", 8'(lowSpeedOut), 8'd1);
    ack();

    suspendReqIn = 1'b1; step(); suspendReqIn = 1'b0;
    check("attached_ignore_suspend", 8'(portStateOut), 8'd2);

    // Bus reset and recovery timing
    resetReqIn = 1'b1; step(); resetReqIn = 1'b0;
    check("bus_reset_state", 8'(portStateOut), 8'd3);
    cnt = 0;
    while (forceSE0Out === 1'b1 && cnt < 100) begin
      if (forceKOut !== 1'b0 || sofEnableOut !== 1'b0) check("se0_exclusive", 8'h1, 8'h0);
      cnt++; step();
    end
    check("se0_cycles", 8'(cnt), 8'd16);
    check("recovery_state", 8'(portStateOut), 8'd4);
    cnt = 0;
    while (portStateOut === 3'd4 && cnt < 100) begin
      if ({forceSE0Out, forceKOut, sofEnableOut} !== 3'b000) check("recovery_idle", 8'h1, 8'h0);
      cnt++; step();
    end
    check("recovery_cycles", 8'(cnt), 8'd4);
    check("enabled_state", 8'(portStateOut), 8'd5);
    check("enabled_drives", 8'({forceSE0Out, forceKOut, sofEnableOut}), 8'h1);

    // Suspend and resume
    suspendReqIn = 1'b1; step(); suspendReqIn = 1'b0;
    check("suspended_state", 8'(portStateOut), 8'd6);
    check("suspended_sof", 8'(sofEnableOut), 8'd0);
    resumeReqIn = 1'b1; step(); resumeReqIn = 1'b0;
    check("resume_state", 8'(portStateOut), 8'd7);
    cnt = 0;
    while (forceKOut === 1'b1 && cnt < 100) begin
      if (forceSE0Out !== 1'b0 || sofEnableOut !== 1'b0) check("k_exclusive", 8'h1, 8'h0);
      cnt++; step();
    end
    check("k_cycles", 8'(cnt), 8'd12);
    check("resume_done_state", 8'(portStateOut), 8'd5);
    check("resume_irq", 8'({irqOut, irqCauseOut}), 8'h6);
    ack();
    check("resume_ack", 8'({irqOut, irqCauseOut}), 8'h0);

    // Reset beats suspend; disconnect ignored while driving SE0
    suspendReqIn = 1'b1; resetReqIn = 1'b1; step(); suspendReqIn = 1'b0; resetReqIn = 1'b0;
    check("reset_over_suspend", 8'(portStateOut), 8'd3);
    connectStateIn = 2'b00; connectionEventIn = 1'b1; step(); connectionEventIn = 1'b0;
    check("bus_reset_ignore_disc", 8'(portStateOut), 8'd3);
    check("bus_reset_ignore_irq", 8'(irqCauseOut), 8'h0);
    connectStateIn = 2'b01;
    wait_state(3'd5, "reenable");

    // Disconnect beats a simultaneous reset request
    connectStateIn = 2'b00; connectionEventIn = 1'b1; resetReqIn = 1'b1; step();
    connectionEventIn = 1'b0; resetReqIn = 1'b0;
    check("disc_over_reset", 8'(portStateOut), 8'd0);
    check("disc_over_reset_irq", 8'(irqCauseOut), 8'h1);
    check("disc_sof_off", 8'(sofEnableOut), 8'd0);
    ack();

    // Synchronous reset in the middle of BUS_RESET
    connectStateIn = 2'b01;
    wait_state(3'd2, "reattach");
    check("reattach_ls", 8'(lowSpeedOut), 8'd1);
    ack();
    resetReqIn = 1'b1; step(); resetReqIn = 1'b0;
    check("mid_bus_reset_se0", 8'(forceSE0Out), 8'd1);
    repeat (2) step();
    rst = 1'b1; step(); rst = 1'b0;
    check("mid_rst_state", 8'(portStateOut), 8'd0);
    check("mid_rst_outputs", 8'({forceSE0Out, forceKOut, sofEnableOut, lowSpeedOut, irqCauseOut}), 8'h0);

    // Remote wake from SUSPENDED
    wait_state(3'd2, "rw_attach");
    resetReqIn = 1'b1; step(); resetReqIn = 1'b0;
    wait_state(3'd5, "rw_enable");
    suspendReqIn = 1'b1; step(); suspendReqIn = 1'b0;
    check("rw_suspended", 8'(portStateOut), 8'd6);
    resumeIntIn = 1'b1; step(); resumeIntIn = 1'b0;
`ifdef PORT_SEQ_REMOTE_WAKE_EN
    check("remote_wake", 8'(portStateOut), 8'd7);
    check("remote_wake_k", 8'(forceKOut), 8'd1);
`else
    check("remote_wake", 8'(portStateOut), 8'd6);
    check("remote_wake_k", 8'(forceKOut), 8'd0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
